// File: rtl/enum_sched.sv
// Round-robin owner arbitration for one shared enumerator: grants one client per
// session, latches its {max,step,min}, and forwards the pull/ack handshake.
module enum_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        cl_start,
  input  logic [NREQ*3*W-1:0]    cl_cfg,
  input  logic [NREQ-1:0]        cl_req,
  output logic [NREQ-1:0]        cl_grant,
  output logic [NREQ-1:0]        cl_ack,
  output logic                   cl_eol,
  output logic [NREQ-1:0]        cl_done,
  output logic [W-1:0]           value,
  output logic                   en_ready,
  output logic [W-1:0]           en_min,
  output logic [W-1:0]           en_step,
  output logic [W-1:0]           en_max,
  output logic                   en_req,
  input  logic                   en_ack,
  input  logic                   en_eol,
  input  logic [W-1:0]           en_value
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            arm_q, arm_d;
  logic [W-1:0]    min_q, min_d;
  logic [W-1:0]    step_q, step_d;
  logic [W-1:0]    max_q, max_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW:0]     cand;
  logic [3*W-1:0]  pick_cfg;
  logic            owner_start;
  logic            owner_req;
  logic            run;
  logic            sess_end;

  // Search starts one past the last owner and wraps modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k + 1);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!pick_found && cl_start[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    pick_cfg = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) pick_cfg = cl_cfg[3*W*i +: 3*W];
    end
  end

  assign owner_start = |(cl_start & grant_q);
  assign owner_req   = |(cl_req & grant_q);
  assign run         = (state_q == RUN);
  assign sess_end    = run && ((en_ack && en_eol) || !owner_start);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    arm_d   = 1'b1;
    min_d   = min_q;
    step_d  = step_q;
    max_d   = max_q;
    case (state_q)
      IDLE: begin
        // arm_q holds off arbitration for the first edge after reset release.
        if (arm_q && pick_found) begin
          state_d = LOAD;
          last_d  = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          {max_d, step_d, min_d} = pick_cfg;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (sess_end) begin
          state_d = GAP;
          grant_d = '0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      arm_q   <= 1'b0;
      min_q   <= '0;
      step_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      arm_q   <= arm_d;
      min_q   <= min_d;
      step_q  <= step_d;
      max_q   <= max_d;
    end
  end

  assign cl_grant = grant_q;
  assign cl_ack   = en_ack ? grant_q : '0;
  assign cl_done  = sess_end ? grant_q : '0;
  assign cl_eol   = run && en_eol;
  assign value    = run ? en_value : '0;
  assign en_ready = (state_q == LOAD) || run;
  assign en_req   = run && owner_req && owner_start;
  assign en_min   = min_q;
  assign en_step  = step_q;
  assign en_max   = max_q;

endmodule

// File: doc/enum_sched.md
ENUM_SCHED -- requirements
Module: enum_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one enumerator (2..8).
REQ-002 The block SHALL have parameter W, default 8, width of min/step/max/value.
REQ-003 The block SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port cl_start  input  NREQ  per-client session request (level); held high for the whole session.
REQ-006 The block SHALL have port cl_cfg  input  NREQ*3*W  per-client {max,step,min}; client i occupies bits [3W*i +: 3W], min in the low W bits.
REQ-007 The block SHALL have port cl_req  input  NREQ  per-client pull for the next value.
REQ-008 The block SHALL have port cl_grant  output  NREQ  one-hot owner of the enumerator; all zero when idle.
REQ-009 The block SHALL have port cl_ack  output  NREQ  per-client value-valid strobe.
REQ-010 The block SHALL have port cl_eol  output  1  end-of-list flag, valid for the granted client.
REQ-011 The block SHALL have port cl_done  output  NREQ  one-cycle pulse marking the end of a client's session.
REQ-012 The block SHALL have port value  output  W  current enumerated value, shared by all clients.
REQ-013 The block SHALL have port en_ready  output  1  ready to the enumerator.
REQ-014 The block SHALL have ports en_min, en_step, en_max  output  W each  latched configuration of the owner.
REQ-015 The block SHALL have port en_req  output  1  pull to the enumerator.
REQ-016 The block SHALL have ports en_ack  input  1, en_eol  input  1, and en_value  input  W, all from the enumerator.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN and GAP.
REQ-018 IDLE: when any cl_start bit is high, the block SHALL grant one client by round-robin, starting the search at (last owner + 1) mod NREQ, latch that client's cfg into en_min/en_step/en_max, set its cl_grant bit, and go to LOAD.
REQ-019 LOAD: the block SHALL assert en_ready, keep en_req low for one cycle, then go to RUN.
REQ-020 RUN: en_ready SHALL stay high; en_req SHALL equal cl_req[owner] & cl_start[owner], passed through combinationally.
REQ-021 cl_ack[owner] SHALL equal en_ack; all other cl_ack bits SHALL be 0.
REQ-022 value SHALL equal en_value, and cl_eol SHALL equal en_eol, while in RUN; otherwise cl_eol SHALL be 0.
REQ-023 Session end: in RUN, the session SHALL end on the first cycle where en_ack & en_eol is high, or on the cycle cl_start[owner] is sampled low.
REQ-024 On session end, cl_done[owner] SHALL pulse for exactly 1 cycle, and the FSM SHALL go to GAP.
REQ-025 GAP: en_ready SHALL be 0, en_req SHALL be 0 and cl_grant SHALL be all zero for exactly 1 cycle, so the enumerator sees a ready low-to-high edge and reloads min; the FSM then goes to IDLE.
REQ-026 Grant-to-first-grant latency SHALL be 1 cycle from cl_start rising while IDLE; minimum session turnaround SHALL be 2 cycles (GAP + IDLE).
REQ-027 Latched cfg SHALL NOT change during a session, even if cl_cfg changes.
REQ-028 A client's cl_req while it is not owner SHALL be ignored and produce no ack.
REQ-029 If cl_start[owner] drops and en_ack arrives in the same cycle, the ack SHALL be forwarded and the session SHALL still end (done pulse the same cycle).
REQ-030 The round-robin pointer SHALL wrap from NREQ-1 to 0.
REQ-031 With a single requester, the same requester SHALL be re-granted after GAP.

Reset
REQ-032 Asserting reset_n low SHALL immediately force: state IDLE; cl_grant, cl_ack, cl_done, cl_eol, en_ready, en_req = 0; en_min/en_step/en_max/value = 0; last owner = NREQ-1 (so client 0 wins first).
REQ-033 Reset mid-session SHALL abort the session without a cl_done pulse.
REQ-034 After release, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-035 Single client 0, cfg min=3 max=6, cl_req held high -> grant[0]; acks with values 3,4,5,6; eol with 6; done[0] pulse; GAP one cycle with en_ready=0.
REQ-036 Clients 0 and 2 both start in the same cycle after reset -> 0 served first, then 2; then 0 restarts -> after 2 finishes, 0 is granted again (wrap).
REQ-037 Owner drops cl_start after 2 values -> done pulse that cycle, GAP, next requester granted; the next session starts again at its own min.
REQ-038 Non-owner client 1 asserts cl_req during client 0's session -> cl_ack[1] stays 0 and en_req follows client 0 only.
REQ-039 cl_cfg for the owner changes mid-session -> en_min/en_max remain the latched values.
REQ-040 reset_n pulsed low during RUN -> all outputs 0 asynchronously, no done pulse, and client 0 is re-granted 2 edges after release if still requesting.
